pipe_control: RTL and testbench
===============================

# pipe_control

Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage opcode into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also owns load-use stall insertion, branch/jump flushing and EX-stage forwarding selects. The datapath consumes its per-stage outputs directly; no separate hazard or forwarding unit exists.

## Interface

- REG_AW, 5, register-address width
- CNT_W, 16, width of stall counter
- ENABLE_ADDI, 1, decode ADDI (001000)
- ENABLE_JUMP, 1, decode J (000010)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_opcode  in  6  opcode in ID
- id_rs, id_rt, id_rd  in  REG_AW each  register fields in ID
- mem_zero  in  1  ALU zero flag registered in EX/MEM
- ex_alu_op  out  2  ALUOp for EX
- ex_alu_src, ex_reg_dst  out  1 each  EX controls
- ex_dst  out  REG_AW  EX destination (ex_reg_dst ? rd : rt)
- mem_read, mem_write, mem_branch  out  1 each  MEM controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
- wb_dst  out  REG_AW  WB destination register
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- pc_write, ifid_write, ifid_flush  out  1 each  front-end controls
- pc_src  out  1  take branch target
- jump  out  1  take jump target
- illegal_op  out  1  ID holds a valid undecodable opcode
- stall_count  out  CNT_W  saturating count of load-use bubbles

## Operation

- Decode (only when id_valid=1, otherwise all-zero bundle):
  - R-type 000000: alu_op=10, reg_dst, reg_write.
  - LW 100011: alu_src, mem_read, reg_write, mem_to_reg, alu_op=00.
  - SW 101011: alu_src, mem_write.
  - BEQ 000100: alu_op=01, branch.
  - ADDI: alu_src, reg_write, alu_op=00.
  - J: jump=1, bundle zero.
  - Any other opcode: zero bundle, illegal_op=1. This includes ADDI/J when the corresponding ENABLE_* is 0.
- Stage registers: ID/EX holds the bundle plus rs, rt, rd. EX/MEM holds the bundle plus ex_dst. MEM/WB holds wb bits plus dst.
- Load-use: load_use = mem_read_in_EX & ex_dst≠0 & (ex_dst==id_rs | ex_dst==id_rt) & id_valid & decoded opcode is R/LW/SW/BEQ/ADDI. The rt compare is conservative for all opcodes.
  - Response: pc_write=0, ifid_write=0, and a zero bundle loads into ID/EX. stall_count increments and saturates at 2^CNT_W−1.
- Branch: pc_src = mem_branch & mem_zero.
  - Response: ifid_flush=1. Zero bundles load into ID/EX and EX/MEM, squashing the instructions in IF, ID and EX.
- Jump (ID): ifid_flush=1. J enters ID/EX as a bubble.
- Priority: pc_src > load_use > jump.
  - When pc_src=1, load_use and jump are ignored, pc_write=1, and stall_count does not increment.
  - When load_use=1 and J is in ID: J reads no registers, so load_use is 0 by definition.
- Forwarding:
  - fwd_a=10 if EX/MEM reg_write & EX/MEM dst≠0 & dst==ex_rs.
  - Otherwise fwd_a=01 if MEM/WB reg_write & wb_dst≠0 & wb_dst==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules against ex_rt. EX/MEM has priority.

## Timing

- All stage control outputs are registered. The bundle decoded in ID at edge N appears at ex_* after edge N, at mem_* after edge N+1, and at wb_* after edge N+2.
- pc_write, ifid_write, ifid_flush, pc_src, jump, illegal_op, fwd_a and fwd_b are combinational from current register state and inputs. They are valid within the same cycle.
- A load-use bubble lasts exactly one cycle. The next cycle re-evaluates with the load in MEM, so load_use=0 and fwd selects 01 for the dependent operand.
- Reset (rst_n low, asynchronous):
  - All stage registers clear, so every ex_*, mem_*, wb_* output is 0, dst=0 and fwd=00.
  - pc_write=1, ifid_write=1, ifid_flush=0, pc_src=0, jump=0, stall_count=0.
  - Reset asserted mid-stall or mid-flush clears state immediately. There is no pending carry-over after release.
- Register 0 is never a hazard or forwarding source.

## Test plan

- Reset released, then LW rt=3 followed by R-type rs=3, rt=4: one cycle with pc_write=0, ifid_write=0, ex_* all 0, stall_count=1. The next cycle has fwd_a=01.
- R-type rd=5 followed by R-type rs=5, rt=5: no stall, fwd_a=fwd_b=10 with the consumer in EX. With one instruction between them, both selects are 01.
- BEQ with mem_zero=1 in MEM while ID holds LW-dependent R-type: pc_src=1, ifid_flush=1, next ex_* and mem_* are 0, no stall, stall_count unchanged.
- J in ID (ENABLE_JUMP=1): jump=1, ifid_flush=1, next ex_* are 0. Repeat with ENABLE_JUMP=0: illegal_op=1, jump=0.
- LW rt=0 followed by R-type rs=0: no stall. Writes to register 0 in MEM produce fwd=00.
- CNT_W=2, four load-use stalls: stall_count reads 1,2,3,3. Asserting rst_n=0 mid-stall forces stall_count=0 and all stage outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_control.sv
// -----------------------------------------------------------------------------
// pipe_control
//
// Control path of the 5-stage MIPS pipeline. Decodes the ID-stage opcode into
// a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage
// registers. It also decides load-use stalls, branch/jump flushes and the
// EX-stage ALU operand forwarding selects.
//
// Parameters
//   REG_AW       register-address width
//   CNT_W        width of the saturating load-use stall counter
//   ENABLE_ADDI  decode ADDI (001000) when non-zero, otherwise it is illegal
//   ENABLE_JUMP  decode J (000010) when non-zero, otherwise it is illegal
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid, id_opcode         instruction presence and opcode in ID
//   id_rs, id_rt, id_rd         register fields in ID
//   mem_zero                    ALU zero flag held in EX/MEM
//   ex_alu_op, ex_alu_src,
//   ex_reg_dst, ex_dst          EX-stage controls and destination register
//   mem_read, mem_write,
//   mem_branch                  MEM-stage controls
//   wb_reg_write, wb_mem_to_reg,
//   wb_dst                      WB-stage controls and destination register
//   fwd_a, fwd_b                operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write, ifid_write,
//   ifid_flush                  front-end controls
//   pc_src, jump                take branch / jump target
//   illegal_op                  valid but undecodable opcode in ID
//   stall_count                 saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module pipe_control #(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 16,
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_JUMP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_zero,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [REG_AW-1:0] ex_dst,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_branch,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              pc_src,
    output logic              jump,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic [1:0] d_alu_op;
    logic       d_alu_src;
    logic       d_reg_dst;
    logic       d_mem_read;
    logic       d_mem_write;
    logic       d_branch;
    logic       d_reg_write;
    logic       d_mem_to_reg;
    logic       d_jump;
    logic       d_illegal;
    logic       d_uses_regs;   // opcode reads rs/rt, so it can be a load-use victim

    always_comb begin
        d_alu_op     = 2'b00;
        d_alu_src    = 1'b0;
        d_reg_dst    = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_branch     = 1'b0;
        d_reg_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_jump       = 1'b0;
        d_illegal    = 1'b0;
        d_uses_regs  = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OP_RTYPE: begin
                    d_alu_op    = 2'b10;
                    d_reg_dst   = 1'b1;
                    d_reg_write = 1'b1;
                    d_uses_regs = 1'b1;
                end
                OP_LW: begin
                    d_alu_src    = 1'b1;
                    d_mem_read   = 1'b1;
                    d_reg_write  = 1'b1;
                    d_mem_to_reg = 1'b1;
                    d_uses_regs  = 1'b1;
                end
                OP_SW: begin
                    d_alu_src   = 1'b1;
                    d_mem_write = 1'b1;
                    d_uses_regs = 1'b1;
                end
                OP_BEQ: begin
                    d_alu_op    = 2'b01;
                    d_branch    = 1'b1;
                    d_uses_regs = 1'b1;
                end
                OP_ADDI: begin
                    if (ENABLE_ADDI != 0) begin
                        d_alu_src   = 1'b1;
                        d_reg_write = 1'b1;
                        d_uses_regs = 1'b1;
                    end else begin
                        d_illegal = 1'b1;
                    end
                end
                OP_J: begin
                    if (ENABLE_JUMP != 0) begin
                        d_jump = 1'b1;
                    end else begin
                        d_illegal = 1'b1;
                    end
                end
                default: d_illegal = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [1:0]        ex_alu_op_reg;
    logic              ex_alu_src_reg;
    logic              ex_reg_dst_reg;
    logic              ex_mem_read_reg;
    logic              ex_mem_write_reg;
    logic              ex_branch_reg;
    logic              ex_reg_write_reg;
    logic              ex_mem_to_reg_reg;
    logic [REG_AW-1:0] ex_rs_reg;
    logic [REG_AW-1:0] ex_rt_reg;
    logic [REG_AW-1:0] ex_rd_reg;

    logic              mem_read_reg;
    logic              mem_write_reg;
    logic              mem_branch_reg;
    logic              mem_reg_write_reg;
    logic              mem_mem_to_reg_reg;
    logic [REG_AW-1:0] mem_dst_reg;

    logic              wb_reg_write_reg;
    logic              wb_mem_to_reg_reg;
    logic [REG_AW-1:0] wb_dst_reg;

    logic [CNT_W-1:0]  stall_count_reg;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] ex_dst_sel;
    logic              load_use;
    logic              stall;
    logic              take_branch;
    logic              id_load;

    assign ex_dst_sel  = ex_reg_dst_reg ? ex_rd_reg : ex_rt_reg;
    assign take_branch = mem_branch_reg & mem_zero;

    // rt is compared for every opcode, even ones that only read rs; this can
    // add a spurious bubble but never misses a real dependency.
    assign load_use = ex_mem_read_reg & (ex_dst_sel != '0)
                    & ((ex_dst_sel == id_rs) | (ex_dst_sel == id_rt))
                    & d_uses_regs;

    // A taken branch squashes the ID instruction, so its stall is moot.
    assign stall = load_use & ~take_branch;

    // ID/EX takes the decoded instruction only when it is a real instruction
    // that is neither stalled, flushed nor a jump (which retires in ID).
    assign id_load = id_valid & ~d_illegal & ~d_jump & ~stall & ~take_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_alu_op_reg      <= 2'b00;
            ex_alu_src_reg     <= 1'b0;
            ex_reg_dst_reg     <= 1'b0;
            ex_mem_read_reg    <= 1'b0;
            ex_mem_write_reg   <= 1'b0;
            ex_branch_reg      <= 1'b0;
            ex_reg_write_reg   <= 1'b0;
            ex_mem_to_reg_reg  <= 1'b0;
            ex_rs_reg          <= '0;
            ex_rt_reg          <= '0;
            ex_rd_reg          <= '0;
        end else if (id_load) begin
            ex_alu_op_reg      <= d_alu_op;
            ex_alu_src_reg     <= d_alu_src;
            ex_reg_dst_reg     <= d_reg_dst;
            ex_mem_read_reg    <= d_mem_read;
            ex_mem_write_reg   <= d_mem_write;
            ex_branch_reg      <= d_branch;
            ex_reg_write_reg   <= d_reg_write;
            ex_mem_to_reg_reg  <= d_mem_to_reg;
            ex_rs_reg          <= id_rs;
            ex_rt_reg          <= id_rt;
            ex_rd_reg          <= id_rd;
        end else begin
            // bubble: fields are cleared too so ex_dst reads 0
            ex_alu_op_reg      <= 2'b00;
            ex_alu_src_reg     <= 1'b0;
            ex_reg_dst_reg     <= 1'b0;
            ex_mem_read_reg    <= 1'b0;
            ex_mem_write_reg   <= 1'b0;
            ex_branch_reg      <= 1'b0;
            ex_reg_write_reg   <= 1'b0;
            ex_mem_to_reg_reg  <= 1'b0;
            ex_rs_reg          <= '0;
            ex_rt_reg          <= '0;
            ex_rd_reg          <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_branch_reg     <= 1'b0;
            mem_reg_write_reg  <= 1'b0;
            mem_mem_to_reg_reg <= 1'b0;
            mem_dst_reg        <= '0;
        end else if (take_branch) begin
            // the instruction in EX is on the wrong path
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_branch_reg     <= 1'b0;
            mem_reg_write_reg  <= 1'b0;
            mem_mem_to_reg_reg <= 1'b0;
            mem_dst_reg        <= '0;
        end else begin
            mem_read_reg       <= ex_mem_read_reg;
            mem_write_reg      <= ex_mem_write_reg;
            mem_branch_reg     <= ex_branch_reg;
            mem_reg_write_reg  <= ex_reg_write_reg;
            mem_mem_to_reg_reg <= ex_mem_to_reg_reg;
            mem_dst_reg        <= ex_dst_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write_reg  <= 1'b0;
            wb_mem_to_reg_reg <= 1'b0;
            wb_dst_reg        <= '0;
        end else begin
            wb_reg_write_reg  <= mem_reg_write_reg;
            wb_mem_to_reg_reg <= mem_mem_to_reg_reg;
            wb_dst_reg        <= mem_dst_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: operand 0 compares against rs, operand 1 against rt
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] fwd_src [2];
    logic [1:0]        fwd_sel [2];

    assign fwd_src[0] = ex_rs_reg;
    assign fwd_src[1] = ex_rt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (mem_reg_write_reg && (mem_dst_reg != '0) && (mem_dst_reg == fwd_src[gi])) begin
                    fwd_sel[gi] = 2'b10;
                end else if (wb_reg_write_reg && (wb_dst_reg != '0) && (wb_dst_reg == fwd_src[gi])) begin
                    fwd_sel[gi] = 2'b01;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_alu_op     = ex_alu_op_reg;
    assign ex_alu_src    = ex_alu_src_reg;
    assign ex_reg_dst    = ex_reg_dst_reg;
    assign ex_dst        = ex_dst_sel;
    assign mem_read      = mem_read_reg;
    assign mem_write     = mem_write_reg;
    assign mem_branch    = mem_branch_reg;
    assign wb_reg_write  = wb_reg_write_reg;
    assign wb_mem_to_reg = wb_mem_to_reg_reg;
    assign wb_dst        = wb_dst_reg;
    assign fwd_a         = fwd_sel[0];
    assign fwd_b         = fwd_sel[1];
    assign pc_src        = take_branch;
    assign jump          = d_jump & ~take_branch;
    assign pc_write      = ~stall;
    assign ifid_write    = ~stall;
    assign ifid_flush    = take_branch | (d_jump & ~take_branch);
    assign illegal_op    = d_illegal;
    assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_pipe_control.sv
// -----------------------------------------------------------------------------
// tb_pipe_control
//
// Directed bench for pipe_control. Two instances share the ID inputs:
//   u_dut  : CNT_W=2, ADDI and J enabled (saturation visible after 3 stalls)
//   u_alt  : CNT_W=16, ADDI and J disabled (both opcodes become illegal)
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked there, combinational outputs 1 unit later.
// -----------------------------------------------------------------------------
module tb_pipe_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       mem_zero;

    // u_dut outputs
    logic [1:0] ex_alu_op;
    logic       ex_alu_src, ex_reg_dst;
    logic [4:0] ex_dst;
    logic       mem_read, mem_write, mem_branch;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_write, ifid_write, ifid_flush, pc_src, jump, illegal_op;
    logic [1:0] stall_count;

    // u_alt outputs
    logic [1:0]  a_ex_alu_op;
    logic        a_ex_alu_src, a_ex_reg_dst;
    logic [4:0]  a_ex_dst;
    logic        a_mem_read, a_mem_write, a_mem_branch;
    logic        a_wb_reg_write, a_wb_mem_to_reg;
    logic [4:0]  a_wb_dst;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_pc_src, a_jump, a_illegal_op;
    logic [15:0] a_stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_control #(.REG_AW(5), .CNT_W(2), .ENABLE_ADDI(1), .ENABLE_JUMP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_dst(ex_dst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_branch(mem_branch), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_src(pc_src), .jump(jump), .illegal_op(illegal_op), .stall_count(stall_count)
    );

    pipe_control #(.REG_AW(5), .CNT_W(16), .ENABLE_ADDI(0), .ENABLE_JUMP(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_alu_op(a_ex_alu_op), .ex_alu_src(a_ex_alu_src), .ex_reg_dst(a_ex_reg_dst),
        .ex_dst(a_ex_dst), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_branch(a_mem_branch), .wb_reg_write(a_wb_reg_write),
        .wb_mem_to_reg(a_wb_mem_to_reg), .wb_dst(a_wb_dst), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .pc_src(a_pc_src), .jump(a_jump), .illegal_op(a_illegal_op), .stall_count(a_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sat_exp [4];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;

        rst_n    = 1'b0;
        mem_zero = 1'b0;
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        #3;
        // ---------------- reset state ----------------
        chk("rst ex_alu_op",  32'(ex_alu_op), 0);
        chk("rst ex_dst",     32'(ex_dst), 0);
        chk("rst wb_dst",     32'(wb_dst), 0);
        chk("rst fwd_a",      32'(fwd_a), 0);
        chk("rst pc_write",   32'(pc_write), 1);
        chk("rst ifid_write", 32'(ifid_write), 1);
        chk("rst ifid_flush", 32'(ifid_flush), 0);
        chk("rst stall_count",32'(stall_count), 0);
        $display("reset checked");

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- load-use: LW r3 then R r3,r4 ----------------
        set_id(1'b1, OP_LW, 5'd1, 5'd3, 5'd0);
        tick();
        chk("lw ex_alu_src", 32'(ex_alu_src), 1);
        chk("lw ex_dst",     32'(ex_dst), 3);
        set_id(1'b1, OP_R, 5'd3, 5'd4, 5'd6);
        #1;
        chk("lu pc_write",   32'(pc_write), 0);
        chk("lu ifid_write", 32'(ifid_write), 0);
        tick();
        chk("lu bubble ex_alu_op", 32'(ex_alu_op), 0);
        chk("lu bubble ex_alu_src",32'(ex_alu_src), 0);
        chk("lu bubble ex_dst",    32'(ex_dst), 0);
        chk("lu stall_count",      32'(stall_count), 1);
        chk("lu mem_read",         32'(mem_read), 1);
        chk("lu pc_write resumes", 32'(pc_write), 1);
        tick();
        chk("lu wb_dst",      32'(wb_dst), 3);
        chk("lu wb_mem_to_reg", 32'(wb_mem_to_reg), 1);
        chk("lu fwd_a",       32'(fwd_a), 2'b01);
        chk("lu fwd_b",       32'(fwd_b), 2'b00);
        chk("lu ex_alu_op",   32'(ex_alu_op), 2'b10);
        $display("load-use transaction checked");

        // ---------------- EX/MEM forwarding ----------------
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
        tick();
        set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd7);
        #1;
        chk("f10 pc_write", 32'(pc_write), 1);
        tick();
        chk("f10 fwd_a", 32'(fwd_a), 2'b10);
        chk("f10 fwd_b", 32'(fwd_b), 2'b10);
        $display("ex/mem forwarding checked");

        // ---------------- MEM/WB forwarding ----------------
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd8);
        tick();
        set_id(1'b1, OP_R, 5'd9, 5'd10, 5'd11);
        tick();
        set_id(1'b1, OP_R, 5'd8, 5'd8, 5'd12);
        tick();
        chk("f01 fwd_a", 32'(fwd_a), 2'b01);
        chk("f01 fwd_b", 32'(fwd_b), 2'b01);
        $display("mem/wb forwarding checked");

        // ---------------- EX/MEM priority over MEM/WB ----------------
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd13);
        tick();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd13);
        tick();
        set_id(1'b1, OP_R, 5'd13, 5'd2, 5'd14);
        tick();
        chk("fprio fwd_a", 32'(fwd_a), 2'b10);
        chk("fprio fwd_b", 32'(fwd_b), 2'b00);
        $display("forwarding priority checked");

        // ---------------- taken BEQ over load-use ----------------
        set_id(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        chk("beq ex_alu_op", 32'(ex_alu_op), 2'b01);
        set_id(1'b1, OP_LW, 5'd1, 5'd20, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd20, 5'd21, 5'd22);
        mem_zero = 1'b1;
        #1;
        chk("br mem_branch", 32'(mem_branch), 1);
        chk("br pc_src",     32'(pc_src), 1);
        chk("br ifid_flush", 32'(ifid_flush), 1);
        chk("br pc_write",   32'(pc_write), 1);
        chk("br ifid_write", 32'(ifid_write), 1);
        tick();
        chk("br ex_alu_op",  32'(ex_alu_op), 0);
        chk("br ex_dst",     32'(ex_dst), 0);
        chk("br mem_read",   32'(mem_read), 0);
        chk("br mem_branch clr", 32'(mem_branch), 0);
        chk("br pc_src no branch", 32'(pc_src), 0);
        chk("br stall_count", 32'(stall_count), 1);
        mem_zero = 1'b0;
        $display("branch flush checked");

        // ---------------- J after LW with matching fields ----------------
        set_id(1'b1, OP_LW, 5'd1, 5'd7, 5'd0);
        tick();
        set_id(1'b1, OP_J, 5'd7, 5'd7, 5'd7);
        #1;
        chk("j jump",        32'(jump), 1);
        chk("j ifid_flush",  32'(ifid_flush), 1);
        chk("j pc_write",    32'(pc_write), 1);
        chk("j illegal_op",  32'(illegal_op), 0);
        chk("jdis jump",     32'(a_jump), 0);
        chk("jdis illegal",  32'(a_illegal_op), 1);
        chk("jdis ifid_flush", 32'(a_ifid_flush), 0);
        tick();
        chk("j ex_alu_src", 32'(ex_alu_src), 0);
        chk("j ex_dst",     32'(ex_dst), 0);
        $display("jump checked");

        // ---------------- ADDI, SW, illegal, invalid ----------------
        set_id(1'b1, OP_ADDI, 5'd1, 5'd9, 5'd0);
        #1;
        chk("addi illegal",     32'(illegal_op), 0);
        chk("addidis illegal",  32'(a_illegal_op), 1);
        tick();
        chk("addi ex_alu_src", 32'(ex_alu_src), 1);
        chk("addi ex_dst",     32'(ex_dst), 9);
        chk("addidis ex_alu_src", 32'(a_ex_alu_src), 0);
        set_id(1'b1, OP_SW, 5'd1, 5'd2, 5'd0);
        tick();
        chk("sw ex_alu_src", 32'(ex_alu_src), 1);
        set_id(1'b1, OP_BAD, 5'd1, 5'd2, 5'd3);
        #1;
        chk("bad illegal", 32'(illegal_op), 1);
        tick();
        chk("sw mem_write", 32'(mem_write), 1);
        chk("bad ex_alu_src", 32'(ex_alu_src), 0);
        set_id(1'b0, OP_BAD, 5'd1, 5'd2, 5'd3);
        #1;
        chk("invalid illegal", 32'(illegal_op), 0);
        $display("decode checked");

        // ---------------- register 0 never a hazard/forward source ----------------
        set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd24);
        #1;
        chk("r0 pc_write",   32'(pc_write), 1);
        chk("r0 ifid_write", 32'(ifid_write), 1);
        tick();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd25);
        tick();
        chk("r0 fwd_a", 32'(fwd_a), 0);
        chk("r0 fwd_b", 32'(fwd_b), 0);
        $display("register 0 checked");

        // ---------------- saturating stall counter ----------------
        set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2 stall_count", 32'(stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, OP_LW, 5'd1, 5'd10, 5'd0);
            tick();
            set_id(1'b1, OP_R, 5'd10, 5'd10, 5'd11);
            #1;
            chk("sat pc_write", 32'(pc_write), 0);
            tick();
            chk("sat stall_count", 32'(stall_count), 32'(sat_exp[i]));
            chk("wide stall_count", 32'(a_stall_count), 32'(i + 1));
            $display("stall %0d: count %0d", i, stall_count);
        end

        // ---------------- asynchronous reset mid-stall ----------------
        set_id(1'b1, OP_LW, 5'd1, 5'd10, 5'd0);
        tick();
        set_id(1'b1, OP_R, 5'd10, 5'd10, 5'd11);
        #1;
        chk("mid pc_write pre",   32'(pc_write), 0);
        chk("mid ex_alu_src pre", 32'(ex_alu_src), 1);
        rst_n = 1'b0;
        #1;
        chk("mid stall_count",  32'(stall_count), 0);
        chk("mid wide count",   32'(a_stall_count), 0);
        chk("mid ex_alu_src",   32'(ex_alu_src), 0);
        chk("mid ex_dst",       32'(ex_dst), 0);
        chk("mid mem_read",     32'(mem_read), 0);
        chk("mid wb_reg_write", 32'(wb_reg_write), 0);
        chk("mid pc_write",     32'(pc_write), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post ex_alu_op",     32'(ex_alu_op), 2'b10);
        chk("post stall_count",   32'(stall_count), 0);
        $display("async reset mid-stall checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
